// File: rtl/bch_syndrome_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bch_dec_pkg
//  Description : Shared constants, FSM state type and GF(2^8) helpers for the
//                BCH decoder pipeline (syndrome stage and downstream stages).
//                Field GF(2^8) generated by x^8+x^4+x^3+x^2+1.
//  Revision    : 1.0 - initial release
// ============================================================================
package bch_dec_pkg;

    localparam int             BCH_N    = 141;
    localparam int             BCH_M    = 8;
    localparam logic [BCH_M:0] BCH_POLY = 9'h11D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bch_state_e;

    // Multiply a field element by alpha: shift, reduce if x^M fell out.
    function automatic logic [BCH_M-1:0] gf_mul_alpha(input logic [BCH_M-1:0] a);
        return {a[BCH_M-2:0], 1'b0} ^ (a[BCH_M-1] ? BCH_POLY[BCH_M-1:0] : '0);
    endfunction

    // Squaring is linear in GF(2^m): a^2 = sum a_i * alpha^(2i). Evaluated
    // Horner-style in alpha^2, MSB first.
    function automatic logic [BCH_M-1:0] gf_sq(input logic [BCH_M-1:0] a);
        logic [BCH_M-1:0] r;
        r = '0;
        for (int i = BCH_M - 1; i >= 0; i--) begin
            r = gf_mul_alpha(gf_mul_alpha(r)) ^ {{(BCH_M-1){1'b0}}, a[i]};
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bch_syndrome_calc_if.sv
`default_nettype none
// ============================================================================
//  Interface   : bch_syndrome_calc_if
//  Description : Codeword input handshake and syndrome output handshake of the
//                BCH syndrome stage.
//                master : upstream/downstream side (drives in_valid, in_cw,
//                         out_ready)
//                slave  : syndrome block (drives in_ready, out_valid, s1, s3,
//                         out_err and, with BCH_SYND_EVEN_EN, s2 and s4)
//  Macro       : BCH_SYND_EVEN_EN adds the s2/s4 even-syndrome signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bch_syndrome_calc_if #(
    parameter int N = bch_dec_pkg::BCH_N,
    parameter int M = bch_dec_pkg::BCH_M
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_cw;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] s1;
    logic [M-1:0] s3;
    logic         out_err;
`ifdef BCH_SYND_EVEN_EN
    logic [M-1:0] s2;
    logic [M-1:0] s4;
`endif

`ifdef BCH_SYND_EVEN_EN
    modport master (output in_valid, in_cw, out_ready,
                    input  in_ready, out_valid, s1, s3, out_err, s2, s4);
    modport slave  (input  in_valid, in_cw, out_ready,
                    output in_ready, out_valid, s1, s3, out_err, s2, s4);
`else
    modport master (output in_valid, in_cw, out_ready,
                    input  in_ready, out_valid, s1, s3, out_err);
    modport slave  (input  in_valid, in_cw, out_ready,
                    output in_ready, out_valid, s1, s3, out_err);
`endif
endinterface
`default_nettype wire

// File: rtl/bch_syndrome_calc_gf_const_mul.sv
`default_nettype none
// ============================================================================
//  Module      : gf_const_mul
//  Description : Combinational multiply of a GF(2^M) element by alpha^POWER,
//                built as POWER chained multiply-by-alpha steps.
//  Ports       : a_i - field element in
//                y_o - a_i * alpha^POWER
//  Revision    : 1.0 - initial release
// ============================================================================
module gf_const_mul
    import bch_dec_pkg::*;
#(
    parameter int         M     = BCH_M,
    parameter logic [M:0] POLY  = BCH_POLY,
    parameter int         POWER = 1
) (
    input  wire logic [M-1:0] a_i,
    output logic      [M-1:0] y_o
);

    logic [M-1:0] w_step [0:POWER];

    assign w_step[0] = a_i;

    for (genvar k = 0; k < POWER; k++) begin : g_step
        assign w_step[k+1] = {w_step[k][M-2:0], 1'b0} ^
                             (w_step[k][M-1] ? POLY[M-1:0] : '0);
    end

    assign y_o = w_step[POWER];

endmodule
`default_nettype wire

// File: rtl/bch_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  Module      : bch_syndrome_calc
//  Description : BCH syndrome stage. Accepts one N-bit codeword per handshake,
//                evaluates r(alpha) and r(alpha^3) bit-serially (Horner, MSB
//                first, one bit per clock) and presents S1, S3 and an error
//                flag with a valid/ready handshake.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - bch_syndrome_calc_if.slave (in_valid/in_ready/in_cw,
//                       out_valid/out_ready/s1/s3/out_err[/s2/s4])
//  Macro       : BCH_SYND_EVEN_EN - adds s2 = s1^2 and s4 = s1^4 outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module bch_syndrome_calc
    import bch_dec_pkg::*;
#(
    parameter int         N    = BCH_N,
    parameter int         M    = BCH_M,
    parameter logic [M:0] POLY = BCH_POLY
) (
    input wire logic           clk,
    input wire logic           rst,
    bch_syndrome_calc_if.slave bus
);

    localparam int CW = $clog2(N);

    bch_state_e   state_q, state_d;
    logic [N-1:0] sreg_q,  sreg_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic [M-1:0] acc1_q,  acc1_d;
    logic [M-1:0] acc3_q,  acc3_d;
    logic [M-1:0] s1_q,    s1_d;
    logic [M-1:0] s3_q,    s3_d;
    logic         err_q,   err_d;
    logic         ovld_q,  ovld_d;

    logic [M-1:0] w_acc1_x;
    logic [M-1:0] w_acc3_x;
    logic         w_bit;
    logic [M-1:0] w_s1;

    gf_const_mul #(.M(M), .POLY(POLY), .POWER(1)) u_mul_a1 (
        .a_i (acc1_q),
        .y_o (w_acc1_x)
    );

    gf_const_mul #(.M(M), .POLY(POLY), .POWER(3)) u_mul_a3 (
        .a_i (acc3_q),
        .y_o (w_acc3_x)
    );

    assign w_bit = sreg_q[cnt_q];

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        acc1_d  = acc1_q;
        acc3_d  = acc3_q;
        s1_d    = s1_q;
        s3_d    = s3_q;
        err_d   = err_q;
        ovld_d  = ovld_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sreg_d  = bus.in_cw;
                    acc1_d  = '0;
                    acc3_d  = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc1_d = w_acc1_x ^ {{(M-1){1'b0}}, w_bit};
                acc3_d = w_acc3_x ^ {{(M-1){1'b0}}, w_bit};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // First DONE cycle loads the output registers; the result is
                // then held until the downstream takes it.
                if (!ovld_q) begin
                    ovld_d = 1'b1;
                    s1_d   = acc1_q;
                    s3_d   = acc3_q;
                    err_d  = (|acc1_q) | (|acc3_q);
                end else if (bus.out_ready) begin
                    ovld_d  = 1'b0;
                    s1_d    = '0;
                    s3_d    = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            acc1_q  <= '0;
            acc3_q  <= '0;
            s1_q    <= '0;
            s3_q    <= '0;
            err_q   <= 1'b0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            acc1_q  <= acc1_d;
            acc3_q  <= acc3_d;
            s1_q    <= s1_d;
            s3_q    <= s3_d;
            err_q   <= err_d;
            ovld_q  <= ovld_d;
        end
    end

    assign w_s1          = ovld_q ? s1_q : '0;
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = ovld_q;
    assign bus.s1        = w_s1;
    assign bus.s3        = ovld_q ? s3_q : '0;
    assign bus.out_err   = ovld_q & err_q;

`ifdef BCH_SYND_EVEN_EN
    // Even syndromes follow from S1 by squaring (Frobenius), so they need
    // no extra accumulators and inherit the zero-gating of s1.
    assign bus.s2 = gf_sq(w_s1);
    assign bus.s4 = gf_sq(gf_sq(w_s1));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bch_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bch_syndrome_calc
//  Description : Directed self-checking bench for bch_syndrome_calc.
//  Macro       : BCH_SYND_EVEN_EN - also checks s2/s4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bch_syndrome_calc;

    localparam int N = 141;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bch_syndrome_calc_if bus ();

    bch_syndrome_calc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fails = 0;

    logic [7:0] pow [0:254];

    // Reference GF(2^8) multiply, poly 0x11D, shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    // Minimal polynomial of alpha^e: product of (x + alpha^(e*2^j)), j=0..7.
    function automatic logic [8:0] minpoly(input int e);
        logic [7:0] p [0:8];
        logic [8:0] res;
        int ex;
        for (int k = 0; k <= 8; k++) p[k] = 8'h00;
        p[0] = 8'h01;
        ex = e;
        for (int j = 0; j < 8; j++) begin
            for (int k = 8; k >= 1; k--) p[k] = p[k-1] ^ gmul(p[k], pow[ex]);
            p[0] = gmul(p[0], pow[ex]);
            ex = (ex * 2) % 255;
        end
        for (int k = 0; k <= 8; k++) res[k] = p[k][0];
        return res;
    endfunction

    // Codeword = d(x) * m1(x) * m3(x); roots alpha and alpha^3 by construction.
    function automatic logic [N-1:0] encode(input logic [124:0] d);
        logic [8:0]   m1;
        logic [8:0]   m3;
        logic [16:0]  g;
        logic [N-1:0] cw;
        m1 = minpoly(1);
        m3 = minpoly(3);
        g  = '0;
        for (int i = 0; i <= 8; i++) if (m3[i]) g = g ^ ({8'b0, m1} << i);
        cw = '0;
        for (int i = 0; i < 125; i++) if (d[i]) cw = cw ^ ({{(N-17){1'b0}}, g} << i);
        return cw;
    endfunction

    task automatic send_word(input logic [N-1:0] cw);
        bus.in_cw    = cw;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_cw    = ~cw;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.out_valid && cycles < 400);
    endtask

    task automatic finish_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.s1 !== 8'h00) begin n_fails++; $display("FAIL reset_s1 got %h want 00", bus.s1); end
        n_tests++; if (bus.s3 !== 8'h00) begin n_fails++; $display("FAIL reset_s3 got %h want 00", bus.s3); end
        n_tests++; if (bus.out_err !== 1'b0) begin n_fails++; $display("FAIL reset_err got %b want 0", bus.out_err); end
    endtask

    task automatic test_zero_word();
        int cyc;
        send_word('0);
        wait_valid(cyc);
        n_tests++; if (cyc !== 142) begin n_fails++; $display("FAIL zero_latency got %0d want 142", cyc); end
        n_tests++; if (bus.s1 !== 8'h00) begin n_fails++; $display("FAIL zero_s1 got %h want 00", bus.s1); end
        n_tests++; if (bus.s3 !== 8'h00) begin n_fails++; $display("FAIL zero_s3 got %h want 00", bus.s3); end
        n_tests++; if (bus.out_err !== 1'b0) begin n_fails++; $display("FAIL zero_err got %b want 0", bus.out_err); end
        finish_out();
    endtask

    task automatic test_single_bits();
        int         bitpos [3] = '{0, 2, 8};
        logic [7:0] exp_s1 [3] = '{8'h01, 8'h04, 8'h1D};
        logic [7:0] exp_s3 [3] = '{8'h01, 8'h40, 8'h8F};
`ifdef BCH_SYND_EVEN_EN
        logic [7:0] exp_s2 [3] = '{8'h01, 8'h10, 8'h4C};
        logic [7:0] exp_s4 [3] = '{8'h01, 8'h1D, 8'h9D};
`endif
        logic [N-1:0] one;
        int cyc;
        one = '0;
        one[0] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            send_word(one << bitpos[t]);
            wait_valid(cyc);
            n_tests++; if (cyc !== 142) begin n_fails++; $display("FAIL bit%0d_latency got %0d want 142", bitpos[t], cyc); end
            n_tests++; if (bus.s1 !== exp_s1[t]) begin n_fails++; $display("FAIL bit%0d_s1 got %h want %h", bitpos[t], bus.s1, exp_s1[t]); end
            n_tests++; if (bus.s3 !== exp_s3[t]) begin n_fails++; $display("FAIL bit%0d_s3 got %h want %h", bitpos[t], bus.s3, exp_s3[t]); end
            n_tests++; if (bus.out_err !== 1'b1) begin n_fails++; $display("FAIL bit%0d_err got %b want 1", bitpos[t], bus.out_err); end
`ifdef BCH_SYND_EVEN_EN
            n_tests++; if (bus.s2 !== exp_s2[t]) begin n_fails++; $display("FAIL bit%0d_s2 got %h want %h", bitpos[t], bus.s2, exp_s2[t]); end
            n_tests++; if (bus.s4 !== exp_s4[t]) begin n_fails++; $display("FAIL bit%0d_s4 got %h want %h", bitpos[t], bus.s4, exp_s4[t]); end
`endif
            finish_out();
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] cw;
        int cyc;
        cw = '0;
        cw[8] = 1'b1;
        send_word(cw);
        wait_valid(cyc);
        n_tests++; if (cyc !== 142) begin n_fails++; $display("FAIL bp_latency got %0d want 142", cyc); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n_tests++; if (bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", i, bus.out_valid); end
            n_tests++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_hold_in_ready cyc %0d got %b want 0", i, bus.in_ready); end
            n_tests++; if (bus.s1 !== 8'h1D) begin n_fails++; $display("FAIL bp_hold_s1 cyc %0d got %h want 1d", i, bus.s1); end
            n_tests++; if (bus.s3 !== 8'h8F) begin n_fails++; $display("FAIL bp_hold_s3 cyc %0d got %h want 8f", i, bus.s3); end
        end
        finish_out();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
        n_tests++; if (bus.s1 !== 8'h00) begin n_fails++; $display("FAIL bp_release_s1 got %h want 00", bus.s1); end
    endtask

    task automatic test_codewords();
        logic [124:0] data;
        logic [N-1:0] cw;
        int cyc;
        // Data 0 and an arbitrary message polynomial.
        for (int t = 0; t < 2; t++) begin
            data = (t == 0) ? '0 : 125'h1_A5F3C961_23456789_ABCDEF01_3572468;
            cw = encode(data);
            send_word(cw);
            wait_valid(cyc);
            n_tests++; if (bus.s1 !== 8'h00) begin n_fails++; $display("FAIL cw%0d_s1 got %h want 00", t, bus.s1); end
            n_tests++; if (bus.s3 !== 8'h00) begin n_fails++; $display("FAIL cw%0d_s3 got %h want 00", t, bus.s3); end
            n_tests++; if (bus.out_err !== 1'b0) begin n_fails++; $display("FAIL cw%0d_err got %b want 0", t, bus.out_err); end
            finish_out();
        end
        // Single error in the MSB position: S1 = alpha^140, S3 = alpha^(420 mod 255).
        cw[140] = ~cw[140];
        send_word(cw);
        wait_valid(cyc);
        n_tests++; if (bus.s1 !== pow[140]) begin n_fails++; $display("FAIL cwerr_s1 got %h want %h", bus.s1, pow[140]); end
        n_tests++; if (bus.s3 !== pow[165]) begin n_fails++; $display("FAIL cwerr_s3 got %h want %h", bus.s3, pow[165]); end
        n_tests++; if (bus.out_err !== 1'b1) begin n_fails++; $display("FAIL cwerr_err got %b want 1", bus.out_err); end
        finish_out();
    endtask

    task automatic test_reset_mid_run();
        logic [N-1:0] cw;
        int cyc;
        int spurious;
        cw = '0;
        cw[2] = 1'b1;
        send_word(cw);
        repeat (69) @(posedge clk);
        #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL run_in_ready got %b want 0", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0 || bus.s1 !== 8'h00) begin n_fails++; $display("FAIL run_outputs got v=%b s1=%h want v=0 s1=00", bus.out_valid, bus.s1); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.s1 !== 8'h00 || bus.s3 !== 8'h00 || bus.out_err !== 1'b0) begin n_fails++; $display("FAIL midrst_outputs got s1=%h s3=%h err=%b want 0", bus.s1, bus.s3, bus.out_err); end
        spurious = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) spurious++;
        end
        n_tests++; if (spurious !== 0) begin n_fails++; $display("FAIL midrst_idle got %0d busy cycles want 0", spurious); end
        cw = '0;
        cw[8] = 1'b1;
        send_word(cw);
        wait_valid(cyc);
        n_tests++; if (cyc !== 142) begin n_fails++; $display("FAIL postrst_latency got %0d want 142", cyc); end
        n_tests++; if (bus.s1 !== 8'h1D) begin n_fails++; $display("FAIL postrst_s1 got %h want 1d", bus.s1); end
        n_tests++; if (bus.s3 !== 8'h8F) begin n_fails++; $display("FAIL postrst_s3 got %h want 8f", bus.s3); end
        finish_out();
    endtask

    task automatic test_reset_done();
        logic [N-1:0] cw;
        int cyc;
        cw = '0;
        cw[2] = 1'b1;
        send_word(cw);
        wait_valid(cyc);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL donerst_pre_valid got %b want 1", bus.out_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL donerst_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL donerst_in_ready got %b want 1", bus.in_ready); end
        n_tests++; if (bus.s1 !== 8'h00 || bus.out_err !== 1'b0) begin n_fails++; $display("FAIL donerst_outputs got s1=%h err=%b want 00/0", bus.s1, bus.out_err); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] cw;
        int cyc;
        cw = '0;
        cw[8] = 1'b1;
        send_word(cw);
        wait_valid(cyc);
        // Output handshake and a new input offered on the same edge.
        cw = '0;
        cw[2] = 1'b1;
        bus.in_cw     = cw;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL b2b_not_taken got in_ready=%b want 1", bus.in_ready); end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_cw    = '1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL b2b_taken got in_ready=%b want 0", bus.in_ready); end
        wait_valid(cyc);
        n_tests++; if (cyc !== 142) begin n_fails++; $display("FAIL b2b_latency got %0d want 142", cyc); end
        n_tests++; if (bus.s1 !== 8'h04) begin n_fails++; $display("FAIL b2b_s1 got %h want 04", bus.s1); end
        n_tests++; if (bus.s3 !== 8'h40) begin n_fails++; $display("FAIL b2b_s3 got %h want 40", bus.s3); end
        finish_out();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_cw     = '0;
        bus.out_ready = 1'b0;
        pow[0] = 8'h01;
        for (int i = 1; i < 255; i++) pow[i] = gmul(pow[i-1], 8'h02);

        test_reset();
        test_zero_word();
        test_single_bits();
        test_backpressure();
        test_codewords();
        test_reset_mid_run();
        test_reset_done();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
